// File: rtl/tex_dcr_ctrl_pkg.sv
// Shared texture types: DCR address map, controller FSM states and the
// per-stage register image served to the sampler.
package tex_dcr_ctrl_pkg;

    localparam int unsigned TEX_LOD_MAX     = 7;
    localparam int unsigned TEX_LOD_BITS    = 4;
    localparam int unsigned TEX_MIPOFF_BITS = 25;

    localparam logic [7:0] TEX_DCR_STAGE       = 8'h00;
    localparam logic [7:0] TEX_DCR_BADDR       = 8'h01;
    localparam logic [7:0] TEX_DCR_FORMAT      = 8'h02;
    localparam logic [7:0] TEX_DCR_FILTER      = 8'h03;
    localparam logic [7:0] TEX_DCR_WRAPS       = 8'h04;
    localparam logic [7:0] TEX_DCR_LOGDIMS     = 8'h05;
    localparam logic [7:0] TEX_DCR_COMMIT      = 8'h06;
    localparam logic [7:0] TEX_DCR_MIPOFF_BASE = 8'h10;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        COPY
    } tex_dcr_state_t;

    typedef struct packed {
        logic [31:0]                                 baddr;
        logic [TEX_LOD_MAX:0][TEX_MIPOFF_BITS-1:0]   mipoff;
        logic [1:0][TEX_LOD_BITS-1:0]                logdims;
        logic [1:0][1:0]                             wraps;
        logic [2:0]                                  format;
        logic                                        filter;
    } tex_dcrs_t;

endpackage

// File: rtl/tex_inflight_cnt.sv
// Saturating per-stage in-flight request counter with full/empty flags.
module tex_inflight_cnt #(
    parameter int unsigned MAX_INFLIGHT = 16,
    parameter int unsigned CNT_BITS     = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    logic [CNT_BITS-1:0] count_q;
    logic [CNT_BITS-1:0] count_d;

    assign full  = (count_q == CNT_BITS'(MAX_INFLIGHT));
    assign empty = (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (inc && !dec && !full) begin
            count_d = count_q + CNT_BITS'(1);
        end else if (dec && !inc && !empty) begin
            count_d = count_q - CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    a_no_underflow : assert property (@(posedge clk) disable iff (!reset) !(dec && !inc && empty))
        else $error("tex_inflight_cnt: done on empty counter");

endmodule

// File: rtl/tex_dcr_ctrl.sv
// Texture DCR controller: shadow/active register copies per stage, drained
// commit, and one-cycle lookup of the active copy for the sampler.
module tex_dcr_ctrl
    import tex_dcr_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES   = 2,
    parameter int unsigned MAX_INFLIGHT = 16,
    parameter int unsigned STAGE_BITS   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dcr_wr_valid,
    output logic                  dcr_wr_ready,
    input  logic [7:0]            dcr_wr_addr,
    input  logic [31:0]           dcr_wr_data,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [STAGE_BITS-1:0] req_stage,
    output logic                  rsp_valid,
    output tex_dcrs_t             rsp_dcrs,
    input  logic                  done_valid,
    input  logic [STAGE_BITS-1:0] done_stage,
    output logic                  busy
);

    tex_dcr_state_t        state_q, state_d;
    logic [STAGE_BITS-1:0] sel_q, sel_d;
    logic [STAGE_BITS-1:0] cstage_q, cstage_d;
    tex_dcrs_t             shadow_q [NUM_STAGES];
    tex_dcrs_t             shadow_d [NUM_STAGES];
    tex_dcrs_t             active_q [NUM_STAGES];
    tex_dcrs_t             active_d [NUM_STAGES];
    logic                  rsp_valid_q, rsp_valid_d;
    tex_dcrs_t             rsp_dcrs_q, rsp_dcrs_d;

    logic [NUM_STAGES-1:0] cnt_full;
    logic [NUM_STAGES-1:0] cnt_empty;
    logic                  wr_fire;
    logic                  req_fire;

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_cnt
        tex_inflight_cnt #(
            .MAX_INFLIGHT (MAX_INFLIGHT)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (req_fire && (req_stage == STAGE_BITS'(s))),
            .dec   (done_valid && (done_stage == STAGE_BITS'(s))),
            .full  (cnt_full[s]),
            .empty (cnt_empty[s])
        );
    end

    assign dcr_wr_ready = (state_q == IDLE);
    assign wr_fire      = dcr_wr_valid && dcr_wr_ready;
    assign req_fire     = req_valid && req_ready;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_dcrs     = rsp_dcrs_q;
    assign busy         = (state_q != IDLE) || !(&cnt_empty);

    // Only the stage being committed is held off; other stages keep flowing.
    always_comb begin
        req_ready = 1'b1;
        if (cnt_full[req_stage]) begin
            req_ready = 1'b0;
        end
        if ((state_q != IDLE) && (req_stage == cstage_q)) begin
            req_ready = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cstage_d    = cstage_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        rsp_valid_d = req_fire;
        rsp_dcrs_d  = rsp_dcrs_q;

        if (req_fire) begin
            rsp_dcrs_d = active_q[req_stage];
        end

        if (wr_fire) begin
            case (dcr_wr_addr)
                TEX_DCR_STAGE: begin
                    // Range check on the full word so aliased values are ignored too.
                    if (dcr_wr_data < 32'(NUM_STAGES)) begin
                        sel_d = dcr_wr_data[STAGE_BITS-1:0];
                    end
                end
                TEX_DCR_BADDR:   shadow_d[sel_q].baddr    = dcr_wr_data;
                TEX_DCR_FORMAT:  shadow_d[sel_q].format   = dcr_wr_data[2:0];
                TEX_DCR_FILTER:  shadow_d[sel_q].filter   = dcr_wr_data[0];
                TEX_DCR_WRAPS: begin
                    shadow_d[sel_q].wraps[0] = dcr_wr_data[1:0];
                    shadow_d[sel_q].wraps[1] = dcr_wr_data[3:2];
                end
                TEX_DCR_LOGDIMS: begin
                    shadow_d[sel_q].logdims[0] = dcr_wr_data[TEX_LOD_BITS-1:0];
                    shadow_d[sel_q].logdims[1] = dcr_wr_data[16+:TEX_LOD_BITS];
                end
                default: begin
                    for (int unsigned l = 0; l <= TEX_LOD_MAX; l++) begin
                        if (dcr_wr_addr == (TEX_DCR_MIPOFF_BASE + 8'(l))) begin
                            shadow_d[sel_q].mipoff[l] = dcr_wr_data[TEX_MIPOFF_BITS-1:0];
                        end
                    end
                end
            endcase
        end

        case (state_q)
            IDLE: begin
                if (wr_fire && (dcr_wr_addr == TEX_DCR_COMMIT)) begin
                    state_d  = DRAIN;
                    cstage_d = sel_q;
                end
            end
            DRAIN: begin
                if (cnt_empty[cstage_q]) begin
                    state_d = COPY;
                end
            end
            COPY: begin
                active_d[cstage_q] = shadow_q[cstage_q];
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            cstage_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dcrs_q  <= '0;
            for (int unsigned s = 0; s < NUM_STAGES; s++) begin
                shadow_q[s] <= '0;
                active_q[s] <= '0;
            end
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cstage_q    <= cstage_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dcrs_q  <= rsp_dcrs_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
        end
    end

endmodule

// File: tb/tb_tex_dcr_ctrl.sv
// Scoreboard bench for tex_dcr_ctrl: a register model predicts each lookup.
module tb_tex_dcr_ctrl;
    import tex_dcr_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        dcr_wr_valid;
    logic        dcr_wr_ready;
    logic [7:0]  dcr_wr_addr;
    logic [31:0] dcr_wr_data;
    logic        req_valid;
    logic        req_ready;
    logic [0:0]  req_stage;
    logic        rsp_valid;
    tex_dcrs_t   rsp_dcrs;
    logic        done_valid;
    logic [0:0]  done_stage;
    logic        busy;

    tex_dcr_ctrl #(
        .NUM_STAGES   (2),
        .MAX_INFLIGHT (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dcr_wr_valid (dcr_wr_valid),
        .dcr_wr_ready (dcr_wr_ready),
        .dcr_wr_addr  (dcr_wr_addr),
        .dcr_wr_data  (dcr_wr_data),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_stage    (req_stage),
        .rsp_valid    (rsp_valid),
        .rsp_dcrs     (rsp_dcrs),
        .done_valid   (done_valid),
        .done_stage   (done_stage),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int        n_tests = 0;
    int        n_fail  = 0;
    tex_dcrs_t exp_q [$];
    tex_dcrs_t last_rsp;
    tex_dcrs_t shadow_m [2];
    tex_dcrs_t active_m [2];
    int        sel_m;
    int        cst_m;
    int        cnt_m [2];

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            last_rsp = '0;
            exp_q.delete();
        end else if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("rsp_unexpected", 256'(rsp_valid), 256'(0));
            end else begin
                last_rsp = exp_q.pop_front();
                check_eq("rsp_dcrs", 256'(rsp_dcrs), 256'(last_rsp));
            end
        end else begin
            check_eq("rsp_hold", 256'(rsp_dcrs), 256'(last_rsp));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            shadow_m[s] = '0;
            active_m[s] = '0;
            cnt_m[s]    = 0;
        end
        sel_m = 0;
        cst_m = 0;
    endtask

    task automatic model_wr(input logic [7:0] a, input logic [31:0] d);
        int ia;
        ia = int'(a);
        case (a)
            8'h00: if (d < 32'd2) sel_m = int'(d);
            8'h01: shadow_m[sel_m].baddr = d;
            8'h02: shadow_m[sel_m].format = d[2:0];
            8'h03: shadow_m[sel_m].filter = d[0];
            8'h04: begin
                shadow_m[sel_m].wraps[0] = d[1:0];
                shadow_m[sel_m].wraps[1] = d[3:2];
            end
            8'h05: begin
                shadow_m[sel_m].logdims[0] = d[3:0];
                shadow_m[sel_m].logdims[1] = d[19:16];
            end
            8'h06: cst_m = sel_m;
            default: begin
                if (ia >= 16 && ia <= 16 + int'(TEX_LOD_MAX)) begin
                    shadow_m[sel_m].mipoff[ia-16] = d[TEX_MIPOFF_BITS-1:0];
                end
            end
        endcase
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        dcr_wr_valid = 1'b1;
        dcr_wr_addr  = a;
        dcr_wr_data  = d;
        #1;
        check_eq("wr_ready", 256'(dcr_wr_ready), 256'(1));
        model_wr(a, d);
        step();
        dcr_wr_valid = 1'b0;
    endtask

    task automatic req(input int s);
        req_valid = 1'b1;
        req_stage = 1'(s);
        #1;
        check_eq("req_ready", 256'(req_ready), 256'(1));
        exp_q.push_back(active_m[s]);
        cnt_m[s]++;
        step();
        req_valid = 1'b0;
    endtask

    task automatic done(input int s);
        done_valid = 1'b1;
        done_stage = 1'(s);
        cnt_m[s]--;
        step();
        done_valid = 1'b0;
    endtask

    task automatic drain_all();
        for (int s = 0; s < 2; s++) begin
            while (cnt_m[s] > 0) done(s);
        end
    endtask

    task automatic wait_commit();
        for (int i = 0; i < 64; i++) begin
            if (dcr_wr_ready) break;
            step();
        end
        check_eq("commit_done", 256'(dcr_wr_ready), 256'(1));
        active_m[cst_m] = shadow_m[cst_m];
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rsp_valid"}, 256'(rsp_valid), 256'(0));
        check_eq({tag, "_rsp_dcrs"}, 256'(rsp_dcrs), 256'(0));
        check_eq({tag, "_wr_ready"}, 256'(dcr_wr_ready), 256'(1));
        check_eq({tag, "_req_ready"}, 256'(req_ready), 256'(1));
        check_eq({tag, "_busy"}, 256'(busy), 256'(0));
    endtask

    initial begin
        reset        = 1'b0;
        dcr_wr_valid = 1'b0;
        dcr_wr_addr  = '0;
        dcr_wr_data  = '0;
        req_valid    = 1'b0;
        req_stage    = '0;
        done_valid   = 1'b0;
        done_stage   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;
        step();

        // Commit with nothing outstanding: two-cycle stall, then visible.
        wr(TEX_DCR_STAGE, 32'd1);
        wr(TEX_DCR_BADDR, 32'h8000_0000);
        wr(TEX_DCR_COMMIT, 32'h0);
        check_eq("t1_drain_ready", 256'(dcr_wr_ready), 256'(0));
        check_eq("t1_drain_busy", 256'(busy), 256'(1));
        step();
        check_eq("t1_copy_ready", 256'(dcr_wr_ready), 256'(0));
        step();
        check_eq("t1_idle_ready", 256'(dcr_wr_ready), 256'(1));
        active_m[cst_m] = shadow_m[cst_m];
        req(1);
        req(0);
        drain_all();

        // Commit on stage 0 drains its requests while stage 1 keeps flowing.
        req(0);
        req(0);
        req(0);
        wr(TEX_DCR_STAGE, 32'd0);
        wr(TEX_DCR_FORMAT, 32'd2);
        wr(TEX_DCR_COMMIT, 32'h0);
        for (int i = 0; i < 3; i++) begin
            req_stage = 1'b0;
            #1;
            check_eq("drain_block_s0", 256'(req_ready), 256'(0));
            check_eq("drain_wr_ready", 256'(dcr_wr_ready), 256'(0));
            step();
            done_valid = 1'b1;
            done_stage = 1'b0;
            cnt_m[0]--;
            req(1);
            done_valid = 1'b0;
        end
        wait_commit();
        req(0);
        drain_all();

        // Saturate stage 0, then check simultaneous inc/dec at 15.
        for (int i = 0; i < 16; i++) req(0);
        req_stage = 1'b0;
        #1;
        check_eq("full_block", 256'(req_ready), 256'(0));
        check_eq("full_busy", 256'(busy), 256'(1));
        req_stage = 1'b1;
        #1;
        check_eq("full_other_stage", 256'(req_ready), 256'(1));
        step();
        done(0);
        req_valid  = 1'b1;
        req_stage  = 1'b0;
        done_valid = 1'b1;
        done_stage = 1'b0;
        #1;
        check_eq("incdec_ready", 256'(req_ready), 256'(1));
        exp_q.push_back(active_m[0]);
        step();
        req_valid  = 1'b0;
        done_valid = 1'b0;
        #1;
        check_eq("cnt15_kept", 256'(req_ready), 256'(1));
        step();
        req(0);
        #1;
        check_eq("refull", 256'(req_ready), 256'(0));
        step();
        drain_all();

        // Mipoff write, ignored out-of-range STAGE, dropped unmapped address.
        wr(8'h13, 32'h0000_1ABC);
        wr(TEX_DCR_STAGE, 32'd5);
        wr(8'h7F, 32'hDEAD_BEEF);
        wr(TEX_DCR_COMMIT, 32'h0);
        wait_commit();
        req(0);
        req(1);
        drain_all();

        // Reset in the middle of a drain.
        req(0);
        req(0);
        wr(TEX_DCR_COMMIT, 32'h0);
        #2;
        check_eq("pre_reset_busy", 256'(busy), 256'(1));
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_drain_reset");
        model_reset();
        step();
        reset = 1'b1;
        step();
        req(0);
        req(1);
        step();
        drain_all();
        step();

        check_eq("sb_empty", 256'(exp_q.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tex_dcr_ctrl.md
Name: tex_dcr_ctrl

Overview:
- Owns the texture device-configuration registers (DCRs) for all texture stages.
- Accepts host DCR writes into per-stage shadow copies. On COMMIT, atomically promotes a stage's shadow copy to its active copy, but only after every in-flight sampler request on that stage has drained.
- Serves active tex_dcrs_t to the texture sampler front-end, one lookup per request, and tracks per-stage in-flight counts.
- Sits between the DCR bus and the tex unit's address/sampler pipeline.

Parameters:
- NUM_STAGES, 2, number of texture stages; STAGE_BITS = max(1, clog2(NUM_STAGES)).
- MAX_INFLIGHT, 16, per-stage outstanding-request limit; CNT_BITS = clog2(MAX_INFLIGHT+1).

Ports:
- clk, in, 1, clock.
- reset, in, 1, reset; asynchronous, active-low.
- dcr_wr_valid, in, 1, DCR write strobe.
- dcr_wr_ready, out, 1, controller accepts the DCR write.
- dcr_wr_addr, in, 8, DCR register address.
- dcr_wr_data, in, 32, DCR write data.
- req_valid, in, 1, sampler lookup request.
- req_ready, out, 1, lookup accepted.
- req_stage, in, STAGE_BITS, stage of the lookup.
- rsp_valid, out, 1, lookup result valid.
- rsp_dcrs, out, $bits(tex_dcrs_t), active DCRs of the requested stage.
- done_valid, in, 1, sampler finished one request.
- done_stage, in, STAGE_BITS, stage of the finished request.
- busy, out, 1, high when FSM is not IDLE or any in-flight count is nonzero.

Behaviour:
- Reset (asynchronous, active-low): all shadow and active DCRs 0; sel_stage 0; all in-flight counters 0; FSM IDLE.
- Output values during reset: rsp_valid 0, rsp_dcrs 0, dcr_wr_ready 1, req_ready 1, busy 0.
- Reset asserted mid-DRAIN: aborts the commit; active copy keeps its reset value of 0.
- DCR write fires on dcr_wr_valid & dcr_wr_ready. dcr_wr_ready = (state == IDLE).
- Address map, applied to shadow[sel_stage]:
  - 0x00 STAGE: sel_stage <= data[STAGE_BITS-1:0]; ignored if the value is >= NUM_STAGES.
  - 0x01 BADDR: baddr <= data.
  - 0x02 FORMAT: format <= data[2:0].
  - 0x03 FILTER: filter <= data[0].
  - 0x04 WRAPS: wraps[0] <= data[1:0]; wraps[1] <= data[3:2].
  - 0x05 LOGDIMS: logdims[0] <= data[LOD_BITS-1:0]; logdims[1] <= data[16+:LOD_BITS].
  - 0x06 COMMIT: data is ignored; FSM goes IDLE -> DRAIN with cstage <= sel_stage.
  - 0x10+l, for l in 0..TEX_LOD_MAX: mipoff[l] <= data[MIPOFF_BITS-1:0].
  - Any other address: accepted and dropped.
- FSM:
  - IDLE: waits for a COMMIT write.
  - DRAIN: when inflight[cstage] == 0, go to COPY.
  - COPY (1 cycle): active[cstage] <= shadow[cstage]; go to IDLE.
  - Minimum latency, write to COMMIT to new value visible: COMMIT accepted in cycle t; t+1 DRAIN; t+2 COPY; a request fired in t+3 returns the new values.
- Request gating:
  - req_ready = 0 if inflight[req_stage] == MAX_INFLIGHT.
  - req_ready = 0 if state is DRAIN or COPY and req_stage == cstage.
  - Otherwise req_ready = 1.
  - Other stages are never blocked by a commit.
- Lookup timing:
  - Request fires in cycle t -> rsp_valid = 1 in t+1, with rsp_dcrs = active[req_stage] as registered at t.
  - rsp has no backpressure; at most 1 response per cycle.
  - rsp_dcrs holds its last value when rsp_valid = 0.
- In-flight counters:
  - Request fire increments inflight[req_stage].
  - done_valid decrements inflight[done_stage].
  - Inc and dec on the same stage in the same cycle: net 0.
  - done_valid on a zero counter: counter stays 0 (no wrap); simulation assertion error.
- Shadow writes during DRAIN/COPY cannot occur because dcr_wr_ready = 0 in those states.

Decomposition:
- Extend the shared VX_tex_types package:
  - DCR address constants: TEX_DCR_STAGE, TEX_DCR_BADDR, TEX_DCR_FORMAT, TEX_DCR_FILTER, TEX_DCR_WRAPS, TEX_DCR_LOGDIMS, TEX_DCR_COMMIT, TEX_DCR_MIPOFF_BASE = 0x10.
  - FSM enum tex_dcr_state_t {IDLE, DRAIN, COPY}.
  - tex_dcrs_t is used unchanged.
- One sub-module: tex_inflight_cnt, a per-stage saturating up/down counter exposing full and empty flags, instantiated NUM_STAGES times.
- Decode logic and the FSM stay in tex_dcr_ctrl.

Test Plan:
- Reset, then write STAGE=1, BADDR=0x8000_0000, COMMIT; no requests outstanding -> dcr_wr_ready is 0 for exactly 2 cycles. A stage-1 request in t+3 returns baddr 0x8000_0000; stage 0 still returns 0.
- Fire 3 stage-0 requests, then COMMIT stage 0 with a new FORMAT=2 -> FSM holds DRAIN and req_ready is 0 for stage 0 until the 3rd done_valid. COPY follows, and the next lookup shows format 2.
- During a stage-0 DRAIN, stage-1 requests keep firing -> req_ready = 1 and rsp_valid follows 1 cycle later with the stage-1 values.
- Issue 16 stage-0 requests with no done -> req_ready drops to 0 for stage 0. Then a request fire and a done in the same cycle at count 15 -> count stays 15.
- Write MIPOFF 0x10+3 = 0x1ABC, STAGE=5 with NUM_STAGES=2 (ignored), and address 0x7F -> all accepted. The mipoff write lands in mipoff[3] of stage 0 after COMMIT; no other field changes.
- Assert reset in the middle of DRAIN -> every output returns to its reset value immediately; after release the active copy reads 0.
